// File: rtl/fsm_calcetines_pkg.sv
// Shared definitions for the sock-factory controller.
// The package holds the state codes, the product codes, the timing and
// package-size constants, the LED colour codes and small product helpers.
package fsm_calcetines_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_CHECK   = 3'b001,
    ST_KNIT    = 3'b010,
    ST_HEAT    = 3'b011,
    ST_INSPECT = 3'b100,
    ST_PACK    = 3'b101,
    ST_FAULT   = 3'b110
  } state_e;

  typedef enum logic [2:0] {
    P_ALBAJO  = 3'd0,
    P_POLBAJO = 3'd1,
    P_ACBAJO  = 3'd2,
    P_ALALTO  = 3'd3,
    P_ACALTO  = 3'd4
  } prod_e;

  localparam int N_PROD       = 5;
  localparam int KNIT_CYCLES  = 4;
  localparam int HEAT_TIMEOUT = 8;
  localparam int PACK_SIZE    = 6;

  // LED colour field is {red, yellow, green}
  localparam logic [2:0] LED_OFF = 3'b000;
  localparam logic [2:0] LED_GRN = 3'b001;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_RED = 3'b100;

  function automatic logic prod_valid(input logic [2:0] t);
    return t <= P_ACALTO;
  endfunction

  // Codes 011 and 100 belong to the high-sock line
  function automatic logic prod_alto(input logic [2:0] t);
    return (t == P_ALALTO) || (t == P_ACALTO);
  endfunction

  function automatic logic [N_PROD-1:0] prod_onehot(input logic [2:0] t);
    logic [N_PROD-1:0] oh;
    oh = '0;
    for (int k = 0; k < N_PROD; k++) begin
      if (t == 3'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/fsm_calcetines_if.sv
// Signal bundle between the operator/plant side and the sock controller.
// Inputs to the controller: T (product select), PB (start button), SH
// (thread), SRaltos/SRbajos (raw material), TE1/TE2 (heat OK), SI1/SI2
// (inspection pass/reject).  Outputs: per-line state codes and pair counts,
// per-product knitter enables, package fill counts and status LEDs.
// master = plant/operator side, slave = controller.
interface fsm_calcetines_if;
  logic [2:0] T;
  logic       PB, SH, SRaltos, SRbajos, TE1, TE2, SI1, SI2;
  logic [2:0] SEbajos, SEaltos, Cbajos, Caltos;
  logic       Calbajo, Cpolbajo, Cacbajo, Calalto, Cacalto;
  logic [2:0] PACalbajo, PACpolbajo, PACacbajo, PACalalto, PACacalto;
  logic [2:0] LEDalbajo, LEDpolbajo, LEDacbajo, LEDalalto, LEDacalto;

  modport master (
    output T, PB, SH, SRaltos, SRbajos, TE1, TE2, SI1, SI2,
    input  SEbajos, SEaltos, Cbajos, Caltos,
    input  Calbajo, Cpolbajo, Cacbajo, Calalto, Cacalto,
    input  PACalbajo, PACpolbajo, PACacbajo, PACalalto, PACacalto,
    input  LEDalbajo, LEDpolbajo, LEDacbajo, LEDalalto, LEDacalto
  );

  modport slave (
    input  T, PB, SH, SRaltos, SRbajos, TE1, TE2, SI1, SI2,
    output SEbajos, SEaltos, Cbajos, Caltos,
    output Calbajo, Cpolbajo, Cacbajo, Calalto, Cacalto,
    output PACalbajo, PACpolbajo, PACacbajo, PACalalto, PACacalto,
    output LEDalbajo, LEDpolbajo, LEDacbajo, LEDalalto, LEDacalto
  );
endinterface

// File: rtl/pack_counter.sv
// Pairs-per-package counter for one product, counting 0..PACK_SIZE-1.
// Ports: clk, reset (async, active-high), i_inc (count one pair),
// o_count (current fill), o_wrap (this increment completes the package).
module pack_counter
  import fsm_calcetines_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  output logic [2:0] o_count,
  output logic       o_wrap
);

  logic [2:0] r_count;

  // Flag is combinational so the owner can latch it on the same edge
  assign o_wrap  = i_inc && (r_count == 3'(PACK_SIZE - 1));
  assign o_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_wrap ? 3'd0 : r_count + 3'd1;
    end
  end

endmodule

// File: rtl/fsm_calcetines.sv
// Sock-factory production controller.  One job runs at a time:
// IDLE -> CHECK -> KNIT(4) -> HEAT(<=8) -> INSPECT -> PACK -> IDLE, with
// FAULT on missing material or heat timeout.
// Ports: clk, reset (async, active-high), bus (fsm_calcetines_if.slave)
// carrying plant inputs and all status/count outputs.
// All status outputs are registered: they are decoded from the next-state
// values so they line up with the state register after each edge.
module fsm_calcetines
  import fsm_calcetines_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  fsm_calcetines_if.slave  bus
);

  state_e                  r_state, w_state_nxt;
  logic [2:0]              r_prod, w_prod_nxt;
  logic [1:0]              r_knit, w_knit_nxt;
  logic [2:0]              r_heat, w_heat_nxt;
  logic [N_PROD-1:0]       r_green, w_green_nxt;
  logic [N_PROD-1:0]       w_pac_inc, w_pac_wrap;
  logic [N_PROD-1:0][2:0]  w_pac;
  logic [2:0]              r_cnt_bajos, r_cnt_altos;
  logic [2:0]              r_se_bajos, r_se_altos, w_se_bajos_nxt, w_se_altos_nxt;
  logic [N_PROD-1:0]       r_cen, w_cen_nxt;
  logic [N_PROD-1:0][2:0]  r_led, w_led_nxt;
  logic                    w_line_rdy;

  assign w_line_rdy = prod_alto(r_prod) ? bus.SRaltos : bus.SRbajos;
  assign w_pac_inc  = (r_state == ST_PACK) ? prod_onehot(r_prod) : '0;

  for (genvar g = 0; g < N_PROD; g++) begin : g_pac
    pack_counter u_pac (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_pac_inc[g]),
      .o_count (w_pac[g]),
      .o_wrap  (w_pac_wrap[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prod_nxt  = r_prod;
    w_knit_nxt  = r_knit;
    w_heat_nxt  = r_heat;
    // A completed package lights green; a new start of that product clears it
    w_green_nxt = r_green | w_pac_wrap;
    case (r_state)
      ST_IDLE: begin
        if (bus.PB && prod_valid(bus.T)) begin
          w_prod_nxt  = bus.T;
          w_state_nxt = ST_CHECK;
          w_green_nxt = w_green_nxt & ~prod_onehot(bus.T);
        end
      end
      ST_CHECK: begin
        w_knit_nxt  = '0;
        w_state_nxt = (bus.SH && w_line_rdy) ? ST_KNIT : ST_FAULT;
      end
      ST_KNIT: begin
        if (r_knit == 2'(KNIT_CYCLES - 1)) begin
          w_knit_nxt  = '0;
          w_heat_nxt  = '0;
          w_state_nxt = ST_HEAT;
        end else begin
          w_knit_nxt = r_knit + 2'd1;
        end
      end
      ST_HEAT: begin
        if (bus.TE1 && bus.TE2) begin
          w_heat_nxt  = '0;
          w_state_nxt = ST_INSPECT;
        end else if (r_heat == 3'(HEAT_TIMEOUT - 1)) begin
          w_heat_nxt  = '0;
          w_state_nxt = ST_FAULT;
        end else begin
          w_heat_nxt = r_heat + 3'd1;
        end
      end
      ST_INSPECT: begin
        // Reject has priority over pass
        if (bus.SI2)      w_state_nxt = ST_IDLE;
        else if (bus.SI1) w_state_nxt = ST_PACK;
      end
      ST_PACK:  w_state_nxt = ST_IDLE;
      ST_FAULT: if (!bus.PB) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_se_bajos_nxt = prod_alto(w_prod_nxt) ? 3'b000 : w_state_nxt;
    w_se_altos_nxt = prod_alto(w_prod_nxt) ? w_state_nxt : 3'b000;
    w_cen_nxt      = (w_state_nxt == ST_KNIT) ? prod_onehot(w_prod_nxt) : '0;
    for (int k = 0; k < N_PROD; k++) begin
      w_led_nxt[k] = w_green_nxt[k] ? LED_GRN : LED_OFF;
      if (w_prod_nxt == 3'(k)) begin
        if (w_state_nxt == ST_FAULT)     w_led_nxt[k] = LED_RED;
        else if (w_state_nxt != ST_IDLE) w_led_nxt[k] = LED_YEL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prod      <= '0;
      r_knit      <= '0;
      r_heat      <= '0;
      r_green     <= '0;
      r_cnt_bajos <= '0;
      r_cnt_altos <= '0;
      r_se_bajos  <= '0;
      r_se_altos  <= '0;
      r_cen       <= '0;
      r_led       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prod     <= w_prod_nxt;
      r_knit     <= w_knit_nxt;
      r_heat     <= w_heat_nxt;
      r_green    <= w_green_nxt;
      r_se_bajos <= w_se_bajos_nxt;
      r_se_altos <= w_se_altos_nxt;
      r_cen      <= w_cen_nxt;
      r_led      <= w_led_nxt;
      if (r_state == ST_PACK) begin
        if (prod_alto(r_prod)) r_cnt_altos <= r_cnt_altos + 3'd1;
        else                   r_cnt_bajos <= r_cnt_bajos + 3'd1;
      end
    end
  end

  assign bus.SEbajos    = r_se_bajos;
  assign bus.SEaltos    = r_se_altos;
  assign bus.Cbajos     = r_cnt_bajos;
  assign bus.Caltos     = r_cnt_altos;
  assign bus.Calbajo    = r_cen[0];
  assign bus.Cpolbajo   = r_cen[1];
  assign bus.Cacbajo    = r_cen[2];
  assign bus.Calalto    = r_cen[3];
  assign bus.Cacalto    = r_cen[4];
  assign bus.PACalbajo  = w_pac[0];
  assign bus.PACpolbajo = w_pac[1];
  assign bus.PACacbajo  = w_pac[2];
  assign bus.PACalalto  = w_pac[3];
  assign bus.PACacalto  = w_pac[4];
  assign bus.LEDalbajo  = r_led[0];
  assign bus.LEDpolbajo = r_led[1];
  assign bus.LEDacbajo  = r_led[2];
  assign bus.LEDalalto  = r_led[3];
  assign bus.LEDacalto  = r_led[4];

endmodule

// File: tb/tb_fsm_calcetines.sv
// Scoreboard bench for fsm_calcetines: each stimulus cycle pushes the
// expected output snapshot; a monitor pops and compares it after the edge.
module tb_fsm_calcetines;

  localparam logic [2:0] S_IDLE = 3'd0, S_CHECK = 3'd1, S_KNIT = 3'd2,
                         S_HEAT = 3'd3, S_INSP = 3'd4, S_PACK = 3'd5,
                         S_FAULT = 3'd6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsm_calcetines_if bus_if ();

  fsm_calcetines dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct packed {
    logic [2:0]  seb, sea, cb, ca;
    logic [4:0]  cen;
    logic [14:0] pac;
    logic [14:0] led;
  } snap_t;

  snap_t      exp_q[$];
  snap_t      mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_no = 0;
  logic [2:0] exp_cb, exp_ca;
  logic [2:0] exp_pac [5];
  logic       exp_grn [5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t observe();
    snap_t s;
    s.seb = bus_if.SEbajos;
    s.sea = bus_if.SEaltos;
    s.cb  = bus_if.Cbajos;
    s.ca  = bus_if.Caltos;
    s.cen = {bus_if.Cacalto, bus_if.Calalto, bus_if.Cacbajo, bus_if.Cpolbajo, bus_if.Calbajo};
    s.pac = {bus_if.PACacalto, bus_if.PACalalto, bus_if.PACacbajo, bus_if.PACpolbajo, bus_if.PACalbajo};
    s.led = {bus_if.LEDacalto, bus_if.LEDalalto, bus_if.LEDacbajo, bus_if.LEDpolbajo, bus_if.LEDalbajo};
    return s;
  endfunction

  // Expected outputs for a given state and latched product, from the bench's own counters
  function automatic snap_t exp_snap(input logic [2:0] st, input logic [2:0] prod);
    snap_t s;
    logic [2:0] l;
    s.seb = (st != S_IDLE && prod <= 3'd2) ? st : 3'd0;
    s.sea = (st != S_IDLE && prod >= 3'd3) ? st : 3'd0;
    s.cb  = exp_cb;
    s.ca  = exp_ca;
    s.cen = (st == S_KNIT) ? 5'(1 << prod) : 5'd0;
    for (int k = 0; k < 5; k++) begin
      s.pac[k*3 +: 3] = exp_pac[k];
      l = exp_grn[k] ? 3'b001 : 3'b000;
      if (prod == 3'(k)) begin
        if (st == S_FAULT)     l = 3'b100;
        else if (st != S_IDLE) l = 3'b010;
      end
      s.led[k*3 +: 3] = l;
    end
    return s;
  endfunction

  task automatic compare_snap(input string tag, input snap_t o, input snap_t e);
    check_eq({tag, ".SEbajos"}, 32'(o.seb), 32'(e.seb));
    check_eq({tag, ".SEaltos"}, 32'(o.sea), 32'(e.sea));
    check_eq({tag, ".Cbajos"},  32'(o.cb),  32'(e.cb));
    check_eq({tag, ".Caltos"},  32'(o.ca),  32'(e.ca));
    check_eq({tag, ".Cen"},     32'(o.cen), 32'(e.cen));
    check_eq({tag, ".PAC"},     32'(o.pac), 32'(e.pac));
    check_eq({tag, ".LED"},     32'(o.led), 32'(e.led));
  endtask

  always @(posedge clk) begin
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      compare_snap($sformatf("cyc%0d", cyc_no), observe(), mon_e);
    end
  end

  task automatic clear_exp();
    exp_cb = '0;
    exp_ca = '0;
    for (int k = 0; k < 5; k++) begin
      exp_pac[k] = '0;
      exp_grn[k] = 1'b0;
    end
  endtask

  task automatic step(input logic [2:0] st, input logic [2:0] prod);
    exp_q.push_back(exp_snap(st, prod));
    @(posedge clk);
    #2;
  endtask

  // mode 0: good run, 1: inspection reject, 2: heat timeout
  task automatic run(input logic [2:0] prod, input int mode);
    bus_if.T       = prod;
    bus_if.PB      = 1'b1;
    bus_if.SH      = 1'b1;
    bus_if.SRbajos = 1'b1;
    bus_if.SRaltos = 1'b1;
    bus_if.TE1     = 1'b1;
    bus_if.TE2     = (mode != 2);
    bus_if.SI1     = (mode == 0);
    bus_if.SI2     = 1'b0;
    exp_grn[prod]  = 1'b0;
    step(S_CHECK, prod);
    bus_if.PB = 1'b0;
    bus_if.T  = 3'd7;
    for (int i = 0; i < 4; i++) step(S_KNIT, prod);
    if (mode == 2) begin
      for (int i = 0; i < 8; i++) step(S_HEAT, prod);
      step(S_FAULT, prod);
      step(S_IDLE, prod);
    end else if (mode == 1) begin
      step(S_HEAT, prod);
      step(S_INSP, prod);
      step(S_INSP, prod);
      bus_if.SI1 = 1'b1;
      bus_if.SI2 = 1'b1;
      step(S_IDLE, prod);
    end else begin
      step(S_HEAT, prod);
      step(S_INSP, prod);
      step(S_PACK, prod);
      if (prod >= 3'd3) exp_ca = exp_ca + 3'd1;
      else              exp_cb = exp_cb + 3'd1;
      if (exp_pac[prod] == 3'd5) begin
        exp_pac[prod] = 3'd0;
        exp_grn[prod] = 1'b1;
      end else begin
        exp_pac[prod] = exp_pac[prod] + 3'd1;
      end
      step(S_IDLE, prod);
    end
    bus_if.SI1 = 1'b0;
    bus_if.SI2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus_if.T       = 3'd0;
    bus_if.PB      = 1'b0;
    bus_if.SH      = 1'b0;
    bus_if.SRbajos = 1'b0;
    bus_if.SRaltos = 1'b0;
    bus_if.TE1     = 1'b0;
    bus_if.TE2     = 1'b0;
    bus_if.SI1     = 1'b0;
    bus_if.SI2     = 1'b0;
    clear_exp();
    repeat (2) @(posedge clk);
    #2;
    compare_snap("reset", observe(), exp_snap(S_IDLE, 3'd0));
    reset = 1'b0;
    step(S_IDLE, 3'd0);

    // Basic albajo job, 9 edges from PB sample back to IDLE
    run(3'd0, 0);

    // alalto with no raw material: FAULT held by PB, released by PB=0
    bus_if.T       = 3'd3;
    bus_if.PB      = 1'b1;
    bus_if.SH      = 1'b1;
    bus_if.SRaltos = 1'b0;
    bus_if.SRbajos = 1'b1;
    exp_grn[3]     = 1'b0;
    step(S_CHECK, 3'd3);
    step(S_FAULT, 3'd3);
    step(S_FAULT, 3'd3);
    bus_if.PB = 1'b0;
    step(S_IDLE, 3'd3);

    // Six acalto packages fill and wrap; the seventh start turns the LED yellow
    for (int r = 0; r < 7; r++) run(3'd4, 0);

    // Reject with both inspection inputs high, then heat timeout on acbajo
    run(3'd1, 1);
    run(3'd2, 2);

    // Invalid product code is ignored
    bus_if.T  = 3'd7;
    bus_if.PB = 1'b1;
    step(S_IDLE, 3'd0);
    step(S_IDLE, 3'd0);
    bus_if.PB = 1'b0;

    // Asynchronous reset in the middle of KNIT
    bus_if.T  = 3'd0;
    bus_if.PB = 1'b1;
    bus_if.SH = 1'b1;
    exp_grn[0] = 1'b0;
    step(S_CHECK, 3'd0);
    bus_if.PB = 1'b0;
    step(S_KNIT, 3'd0);
    step(S_KNIT, 3'd0);
    reset = 1'b1;
    #1;
    clear_exp();
    compare_snap("async_rst", observe(), exp_snap(S_IDLE, 3'd0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    run(3'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
